// File: rtl/dram_arb.sv
`default_nettype none
// ============================================================================
// Module      : dram_arb
// Description : Two-reader / one-writer arbiter for the frame DRAM. It uses
//               round-robin read grants and stalls a same-address read behind
//               a write. Read returns are tagged back to their clients, and
//               out-of-range accesses set a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_arb #(
    parameter int AW     = 19,
    parameter int DW     = 8,
    parameter int RW     = 392,
    parameter int DEPTH  = 307200,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_gnt,
    input  logic          rd0_req,
    input  logic [AW-1:0] rd0_addr,
    output logic          rd0_gnt,
    output logic          rd0_valid,
    output logic [RW-1:0] rd0_data,
    input  logic          rd1_req,
    input  logic [AW-1:0] rd1_addr,
    output logic          rd1_gnt,
    output logic          rd1_valid,
    output logic [RW-1:0] rd1_data,
    output logic          ren,
    output logic [AW-1:0] raddr,
    output logic          wen,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    input  logic [RW-1:0] rdata,
    output logic          err
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic              r_rr;
    logic [RD_LAT-1:0] r_tag_vld;
    logic [RD_LAT-1:0] r_tag_id;
    logic [RD_LAT-1:0] r_tag_oor;

    logic              w_both;
    logic              w_any;
    logic              w_sel;
    logic [AW-1:0]     w_win_addr;
    logic              w_win_inr;
    logic              w_wr_inr;
    logic              w_hazard;
    logic              w_rd_gnt;
    logic              w_tail_vld;
    logic              w_tail_id;
    logic              w_tail_oor;

    // Grants are suppressed while rst is high so traffic held through reset is ignored.
    always_comb begin
        w_both     = rd0_req & rd1_req;
        w_any      = (rd0_req | rd1_req) & ~rst;
        w_sel      = w_both ? r_rr : rd1_req;
        w_win_addr = w_sel ? rd1_addr : rd0_addr;
        w_win_inr  = ({1'b0, w_win_addr} < c_depth);
        w_wr_inr   = ({1'b0, wr_addr} < c_depth);
        w_hazard   = w_any & wr_req & w_wr_inr & (w_win_addr == wr_addr);
        w_rd_gnt   = w_any & ~w_hazard;

        rd0_gnt    = w_rd_gnt & ~w_sel;
        rd1_gnt    = w_rd_gnt & w_sel;
        ren        = w_rd_gnt & w_win_inr;
        raddr      = ren ? w_win_addr : '0;

        wr_gnt     = wr_req & ~rst;
        wen        = wr_gnt & w_wr_inr;
        waddr      = wen ? wr_addr : '0;
        wdata      = wen ? wr_data : '0;

        w_tail_vld = r_tag_vld[RD_LAT-1];
        w_tail_id  = r_tag_id[RD_LAT-1];
        w_tail_oor = r_tag_oor[RD_LAT-1];
    end

    // Tag pipeline: shifts toward the MSB, and the MSB lines up with rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
            r_tag_oor <= '0;
        end else begin
            r_tag_vld <= RD_LAT'({r_tag_vld, w_rd_gnt});
            r_tag_id  <= RD_LAT'({r_tag_id, w_sel});
            r_tag_oor <= RD_LAT'({r_tag_oor, ~w_win_inr});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (w_rd_gnt && w_both) begin
                r_rr <= ~r_rr;
            end
            if ((w_rd_gnt && !w_win_inr) || (wr_gnt && !w_wr_inr)) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd0_valid <= 1'b0;
            rd1_valid <= 1'b0;
            rd0_data  <= '0;
            rd1_data  <= '0;
        end else begin
            rd0_valid <= w_tail_vld & ~w_tail_id;
            rd1_valid <= w_tail_vld & w_tail_id;
            if (w_tail_vld && !w_tail_id) begin
                rd0_data <= w_tail_oor ? '0 : rdata;
            end
            if (w_tail_vld && w_tail_id) begin
                rd1_data <= w_tail_oor ? '0 : rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/dram_arb.md
# dram_arb

Request arbiter and sequencer for the frame DRAM (`dram_ori`: 19-bit addresses, 8-bit write port, 392-bit (49-byte) read port). Two read clients (rd0 and rd1, e.g. the convolution and pooling engines) and one write client (the frame loader) share the single DRAM instance. The block grants accesses and resolves same-address read/write hazards. It routes each delayed read return back to the client that issued it, and flags out-of-range addresses.

## Interface
- `AW`, 19: address width.
- `DW`, 8: write data width.
- `RW`, 392: read data width.
- `DEPTH`, 307200: number of valid addresses (640x480). Valid addresses are 0..DEPTH-1.
- `RD_LAT`, 1: DRAM read latency in cycles, counted from the edge that samples `ren` to the cycle `rdata` is valid. Legal range is 1..4.
- `clk` in 1: single clock. All state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_req` in 1, `wr_addr` in AW, `wr_data` in DW, `wr_gnt` out 1: write client.
- `rd0_req` in 1, `rd0_addr` in AW, `rd0_gnt` out 1: read client 0 request.
- `rd0_valid` out 1, `rd0_data` out RW: read client 0 return.
- `rd1_req`, `rd1_addr`, `rd1_gnt`, `rd1_valid`, `rd1_data`: same as client 0, for client 1.
- `ren` out 1, `raddr` out AW: DRAM read port.
- `wen` out 1, `waddr` out AW, `wdata` out DW: DRAM write port.
- `rdata` in RW: DRAM read data.
- `err` out 1: sticky flag. Set on any granted out-of-range access. Cleared only by `rst`.

## Operation
- **Handshake.** A transfer occurs in a cycle where req=1 and gnt=1.
  - Gnt is combinational from the req/addr inputs and internal state.
  - A client holds req, addr and data stable until it is granted.
- **Write path.** The write has its own DRAM port and is always granted when `wr_req`=1, so `wr_gnt`=`wr_req`.
  - In range: `wen`=1, with `waddr`/`wdata` driven from the client.
  - Out of range: write dropped (`wen`=0), `err` set.
- **Read arbitration.** At most one read is granted per cycle, chosen round-robin with a 1-bit pointer `rr`.
  - `rr`=0 prefers rd0; `rr`=1 prefers rd1.
  - When both clients request, the preferred client wins and `rr` flips to the other client.
  - A lone requester is granted and `rr` is unchanged.
- **Hazard.** If the read winner's address equals `wr_addr` while `wr_req`=1 and the address is in range, no read is granted that cycle (both read gnts are 0 and `rr` is unchanged). The read is granted the next cycle, so it returns the newly written byte in its slot.
- **DRAM read control.** A granted in-range read drives `ren`=1 and `raddr`=addr. When no read is granted, `ren`=0.
- **Out-of-range read.** The read is granted without a DRAM access and still occupies a return slot. It returns all-zero data, and `err` is set.
- **Return tagging.** A shift register RD_LAT deep carries {valid, client id, oor} for each granted read.
  - At the tail, the owning client's `rdN_valid` pulses for 1 cycle.
  - `rdN_data` is `rdata`, or 0 if the read was out of range.
  - Returns arrive in grant order. At most one valid pulse occurs per cycle across both clients.
- **Data hold.** `rdN_data` is registered and holds its last value when `rdN_valid`=0.

## Timing
- **Reset values.** All gnts 0 (no req is possible to sample during reset). `ren`=0, `wen`=0. `raddr`, `waddr`, `wdata`=0. Both valids 0, both data outputs 0, `err`=0, `rr`=0, tag pipeline cleared.
- **Grant-to-access latency.** The DRAM access occurs in the grant cycle: 0 cycles.
- **Read return.** The valid pulse occurs RD_LAT+1 cycles after the grant edge (1 cycle for output registering). With RD_LAT=1, a grant sampled at edge N gives valid high during cycle N+2.
- **Throughput.** One read per cycle plus one write per cycle, both sustained, with no bubbles except at hazards.
- **Reset mid-operation.** In-flight tags are discarded. No valid pulse for reads granted before `rst`.
- **Simultaneous out-of-range and hazard.** No hazard stall applies, because out-of-range addresses are never written.

## Test plan
- **Reset.** Assert `rst` with traffic on all clients, release -> all outputs 0, `rr`=0, no valid pulses.
- **Back-to-back round-robin.** rd0 and rd1 both request continuously, rd0 addr 0, rd1 addr 1 -> grants alternate rd0, rd1, rd0, ... Each `rdN_valid` arrives 2 cycles after its grant carrying the DRAM word for its address.
- **Hazard.** Write 0xA5 to addr 2 while rd0 reads addr 2 in the same cycle -> `rd0_gnt`=0 that cycle and 1 the next. The returned data byte 0 is 0xA5.
- **Lone requester.** Only rd1 requests, addrs 0x4AFFE then 0x4AFFF -> granted every cycle, `rr` stays 0, two valids to rd1 in order.
- **Out of range.** rd0 reads 0x4B000 and wr writes 0x7FFFF -> both granted, `ren`/`wen` stay 0, `rd0_data`=0 with valid pulse, `err`=1 until `rst`.
- **Reset in flight.** Grant rd0 at edge N, assert `rst` before N+2 -> no `rd0_valid` pulse after reset.
